// File: rtl/store_write_buffer.sv
// Posted-store write buffer between execute and the data bus.
// Define WRITEBUFFER_FWD_EN for store-to-load forwarding and load bypass.
module store_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cpu_valid,
    input  logic            cpu_fence,
    input  logic [AW-1:0]   cpu_addr,
    input  logic [DW-1:0]   cpu_wdata,
    input  logic [DW/8-1:0] cpu_wstrb,
    output logic [DW-1:0]   cpu_rdata,
    output logic            cpu_ready,
    output logic            mem_valid,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wstrb,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_ready,
    output logic            wb_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = DW / 8;

    typedef enum logic [1:0] {IDLE, DRAIN, LOAD} state_t;

    state_t          state;
    logic [AW-1:0]   q_addr [DEPTH];
    logic [DW-1:0]   q_data [DEPTH];
    logic [SW-1:0]   q_strb [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [DW-1:0]   rdata_q;

    logic is_store, is_load, is_fence;
    logic full, empty, push, pop, load_done;
    logic fwd_hit, fwd_byp;
    logic [DW-1:0] fwd_data;

    assign is_store  = cpu_valid & ~cpu_fence & (|cpu_wstrb);
    assign is_load   = cpu_valid & ~cpu_fence & ~(|cpu_wstrb);
    assign is_fence  = cpu_valid & cpu_fence;
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign push      = is_store & ~full;
    assign pop       = (state == DRAIN) & mem_ready;
    assign load_done = (state == LOAD) & mem_ready;

`ifdef WRITEBUFFER_FWD_EN
    logic          fwd_match;
    logic          fwd_full;
    logic [PW-1:0] fwd_idx;

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        fwd_match = 1'b0;
        fwd_full  = 1'b0;
        fwd_data  = '0;
        fwd_idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = rd_ptr + PW'(k);
            if (CW'(k) < count &&
                q_addr[fwd_idx][AW-1:2] == cpu_addr[AW-1:2]) begin
                fwd_match = 1'b1;
                fwd_full  = &q_strb[fwd_idx];
                fwd_data  = q_data[fwd_idx];
            end
        end
    end

    assign fwd_hit = is_load & ~empty & fwd_match & fwd_full
                   & (state != LOAD);
    assign fwd_byp = is_load & ~empty & ~fwd_match;
`else
    assign fwd_hit  = 1'b0;
    assign fwd_byp  = 1'b0;
    assign fwd_data = '0;
`endif

    assign cpu_ready = rst & (push | load_done | fwd_hit
                     | (is_fence & empty & (state == IDLE)));
    assign cpu_rdata = load_done ? mem_rdata
                     : fwd_hit   ? fwd_data
                     : rdata_q;
    assign wb_empty  = empty & (state == IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= cpu_addr;
            q_data[wr_ptr] <= cpu_wdata;
            q_strb[wr_ptr] <= cpu_wstrb;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rdata_q   <= '0;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (fwd_byp || (empty && is_load)) begin
                        state     <= LOAD;
                        mem_valid <= 1'b1;
                        mem_addr  <= cpu_addr;
                        mem_wdata <= '0;
                        mem_wstrb <= '0;
                    end else if (!empty) begin
                        state     <= DRAIN;
                        mem_valid <= 1'b1;
                        mem_addr  <= q_addr[rd_ptr];
                        mem_wdata <= q_data[rd_ptr];
                        mem_wstrb <= q_strb[rd_ptr];
                    end
                end
                DRAIN: begin
                    if (mem_ready) begin
                        state     <= IDLE;
                        mem_valid <= 1'b0;
                    end
                end
                LOAD: begin
                    if (mem_ready) begin
                        state     <= IDLE;
                        mem_valid <= 1'b0;
                        rdata_q   <= mem_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer with a bus responder
// and an in-order scoreboard of expected bus transactions.
module tb_store_write_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_valid, cpu_fence;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [3:0]  cpu_wstrb;
    logic        cpu_ready;
    logic        mem_valid;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        wb_empty;

    store_write_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .cpu_valid(cpu_valid), .cpu_fence(cpu_fence),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_wstrb(cpu_wstrb), .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready), .mem_valid(mem_valid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .wb_empty(wb_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } bus_t;

    bus_t        exp_q[$];
    logic [31:0] bmem [logic [31:0]];
    int ncmp = 0;
    int nfail = 0;
    int cyc = 0;
    int nwr = 0;
    int nbus = 0;
    int last_hs = 0;
    int wcnt = 0;
    int lat = 1;
    logic hold = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus responder: raise mem_ready after lat cycles, check order.
    always @(negedge clk) begin
        if (mem_valid) begin
            wcnt = wcnt + 1;
            if (!hold && wcnt >= lat) begin
                bus_t e;
                mem_ready = 1'b1;
                wcnt = 0;
                nbus++;
                last_hs = cyc;
                chk("bus_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("bus_addr", mem_addr, e.a);
                    chk("bus_strb", 32'(mem_wstrb), 32'(e.s));
                    if (e.s != 4'h0)
                        chk("bus_wdata", mem_wdata, e.d);
                end
                if (mem_wstrb != 4'h0) begin
                    logic [31:0] v;
                    nwr++;
                    v = bmem.exists(mem_addr) ? bmem[mem_addr] : 32'h0;
                    for (int b = 0; b < 4; b++)
                        if (mem_wstrb[b]) v[b*8 +: 8] = mem_wdata[b*8 +: 8];
                    bmem[mem_addr] = v;
                end else begin
                    mem_rdata = bmem.exists(mem_addr) ? bmem[mem_addr]
                                                      : 32'h0;
                end
            end else begin
                mem_ready = 1'b0;
            end
        end else begin
            mem_ready = 1'b0;
            wcnt = 0;
        end
    end

    task automatic do_req(input logic f, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          output int waited, output logic [31:0] rd,
                          output logic mr, output int rc);
        logic ok;
        ok = 1'b0; waited = -1; rd = '0; mr = 1'b0; rc = 0;
        cpu_valid = 1'b1; cpu_fence = f;
        cpu_addr = a; cpu_wdata = d; cpu_wstrb = s;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk); #1;
            if (cpu_ready) begin
                ok = 1'b1; waited = i; rd = cpu_rdata;
                mr = mem_ready; rc = cyc;
            end
        end
        chk("req_timeout", 32'(ok), 1);
        @(posedge clk); #1;
        cpu_valid = 1'b0; cpu_fence = 1'b0; cpu_wstrb = 4'h0;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d,
                      output int waited);
        logic [31:0] rd; logic mr; int rc;
        exp_q.push_back('{a: a, d: d, s: 4'hF});
        do_req(1'b0, a, d, 4'hF, waited, rd, mr, rc);
    endtask

    task automatic wait_empty(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk); #1;
            if (wb_empty && exp_q.size() == 0) ok = 1'b1;
        end
        chk(tag, 32'(ok), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int w, rc, nb0, nw0, seen;
        logic [31:0] rd;
        logic mr;

        rst = 1'b0; cpu_valid = 1'b0; cpu_fence = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_valid", 32'(mem_valid), 0);
        chk("rst_wb_empty", 32'(wb_empty), 1);
        chk("rst_cpu_ready", 32'(cpu_ready), 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // 1: reset while the bus holds a request
        hold = 1'b1;
        st(32'h40, 32'h1111_2222, w);
        chk("t1_store_wait", 32'(w), 0);
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            @(negedge clk); #1;
            if (mem_valid) seen = 1;
        end
        chk("t1_mem_valid_up", 32'(seen), 1);
        rst = 1'b0;
        #1;
        chk("t1_async_drop", 32'(mem_valid), 0);
        chk("t1_wb_empty", 32'(wb_empty), 1);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        hold = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            if (mem_valid) seen++;
        end
        chk("t1_no_stale", 32'(seen), 0);

        // 2: five back-to-back stores into a stalled bus
        hold = 1'b1; lat = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            st(32'h1000 + 32'(i * 4), 32'hA000_0000 + 32'(i), w);
            chk("t2_store_wait", 32'(w), 0);
        end
        exp_q.push_back('{a: 32'h1010, d: 32'hA000_0004, s: 4'hF});
        cpu_valid = 1'b1; cpu_addr = 32'h1010;
        cpu_wdata = 32'hA000_0004; cpu_wstrb = 4'hF;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            if (cpu_ready) seen++;
        end
        chk("t2_full_stall", 32'(seen), 0);
        #1 hold = 1'b0;
        @(negedge clk); #1;
        chk("t2_pop_mem_ready", 32'(mem_ready), 1);
        chk("t2_full_on_pop", 32'(cpu_ready), 0);
        @(negedge clk); #1;
        chk("t2_store5_accept", 32'(cpu_ready), 1);
        @(posedge clk); #1;
        cpu_valid = 1'b0; cpu_wstrb = 4'h0;
        wait_empty("t2_drain");

        // 3: store then load to the same word, bus latency 2
        lat = 2;
        st(32'h100, 32'hDEAD_BEEF, w);
`ifndef WRITEBUFFER_FWD_EN
        exp_q.push_back('{a: 32'h100, d: 32'h0, s: 4'h0});
`endif
        do_req(1'b0, 32'h100, 32'h0, 4'h0, w, rd, mr, rc);
        chk("t3_rdata", rd, 32'hDEAD_BEEF);
`ifndef WRITEBUFFER_FWD_EN
        chk("t3_ready_with_mem_ready", 32'(mr), 1);
`endif
        wait_empty("t3_drain");

        // 4: fence behind three pending stores
        hold = 1'b1; lat = 2;
        for (int i = 0; i < 3; i++)
            st(32'h2000 + 32'(i * 4), 32'hF0F0_0000 + 32'(i), w);
        nw0 = nwr; nb0 = nbus;
        fork
            do_req(1'b1, 32'h0, 32'h0, 4'h0, w, rd, mr, rc);
            begin
                repeat (3) @(negedge clk);
                #2 hold = 1'b0;
            end
        join
        chk("t4_writes_before_fence", 32'(nwr - nw0), 3);
        chk("t4_fence_after_pop", 32'(rc - last_hs), 1);
        repeat (4) @(posedge clk);
        #1;
        chk("t4_no_fence_bus", 32'(nbus - nb0), 3);

        // 5: pointer wrap with drains interleaved
        lat = 1;
        nw0 = nwr;
        for (int i = 0; i < 9; i++)
            st(32'h3000 + 32'(i * 8), $urandom, w);
        wait_empty("t5_drain");
        chk("t5_write_count", 32'(nwr - nw0), 9);

        // 6: forwarding / bypass, or in-order drain without it
        bmem[32'h300] = 32'hCAFE_F00D;
        nb0 = nbus;
        st(32'h200, 32'h1234_5678, w);
`ifndef WRITEBUFFER_FWD_EN
        exp_q.push_back('{a: 32'h200, d: 32'h0, s: 4'h0});
`endif
        do_req(1'b0, 32'h200, 32'h0, 4'h0, w, rd, mr, rc);
        chk("t6_rdata_200", rd, 32'h1234_5678);
`ifdef WRITEBUFFER_FWD_EN
        chk("t6_fwd_same_cycle", 32'(w), 0);
`endif
        wait_empty("t6_drain_a");
`ifdef WRITEBUFFER_FWD_EN
        chk("t6_no_bus_read", 32'(nbus - nb0), 1);
        exp_q.push_back('{a: 32'h300, d: 32'h0, s: 4'h0});
        exp_q.push_back('{a: 32'h204, d: 32'h5555_AAAA, s: 4'hF});
`else
        chk("t6_bus_read", 32'(nbus - nb0), 2);
        exp_q.push_back('{a: 32'h204, d: 32'h5555_AAAA, s: 4'hF});
        exp_q.push_back('{a: 32'h300, d: 32'h0, s: 4'h0});
`endif
        do_req(1'b0, 32'h204, 32'h5555_AAAA, 4'hF, w, rd, mr, rc);
        do_req(1'b0, 32'h300, 32'h0, 4'h0, w, rd, mr, rc);
        chk("t6_rdata_300", rd, 32'hCAFE_F00D);
        wait_empty("t6_drain_b");

        chk("sb_leftover", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end
endmodule
